regfile_access_ctrl: RTL and testbench

- Control stage directly upstream of the register-file cell array.
- Accepts buffered write requests and drains them one per cycle as one-hot row write enables plus a shared write-data bus.
- Decodes two read addresses into one-hot row read enables for the array's tri-state A/B buses, then registers the read data.
- Forwards queued, not-yet-written data so a read always sees every write accepted before it.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_access_ctrl_if.sv | 13 +
 rtl/regfile_wr_queue.sv | 89 ++++++++
 rtl/regfile_access_ctrl.sv | 118 +++++++++++
 tb/tb_regfile_access_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types, default sizes and the one-hot row decoder for the register-file access controller.
package regfile_pkg;

  localparam int NREGS_DEF  = 8;
  localparam int AW_DEF     = 3;
  localparam int DW_DEF     = 8;
  localparam int QDEPTH_DEF = 2;
  localparam int ONEHOT_MAX = 64;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } wr_req_t;

  // Indices at or above ONEHOT_MAX shift out and decode to all zeros.
  function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx);
    return ONEHOT_MAX'(1) << idx;
  endfunction

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Write-request handshake bundle between a requester (master) and the access controller (slave).
interface regfile_access_ctrl_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/regfile_wr_queue.sv
// Circular write FIFO that drains one entry per cycle, with youngest-match lookup for two read ports.
module regfile_wr_queue
  import regfile_pkg::*;
#(
  parameter int  AW     = AW_DEF,
  parameter int  DW     = DW_DEF,
  parameter int  QDEPTH = QDEPTH_DEF,
  parameter type req_t  = wr_req_t
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  req_t          push_req,
  output logic          ready,
  output logic          not_empty,
  output req_t          head_req,
  input  logic [AW-1:0] look_addr_a,
  input  logic [AW-1:0] look_addr_b,
  output logic          hit_a,
  output logic          hit_b,
  output logic [DW-1:0] hit_data_a,
  output logic [DW-1:0] hit_data_b
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  req_t          entries [QDEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [PW-1:0] slot;
  logic          accept;
  logic          pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (int'(p) == QDEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  // Ready comes from registered count only, so a same-cycle pop never frees a slot early.
  assign ready     = (count < CW'(QDEPTH));
  assign not_empty = (count != '0);
  assign pop       = not_empty;
  assign accept    = push && ready;
  assign head_req  = entries[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) tail <= next_ptr(tail);
      if (pop)    head <= next_ptr(head);
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) entries[tail] <= push_req;
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit_a      = 1'b0;
    hit_b      = 1'b0;
    hit_data_a = '0;
    hit_data_b = '0;
    slot       = head;
    for (int i = 0; i < QDEPTH; i++) begin
      slot = PW'((int'(head) + i) % QDEPTH);
      if (i < int'(count)) begin
        if (entries[slot].addr == look_addr_a) begin
          hit_a      = 1'b1;
          hit_data_a = entries[slot].data;
        end
        if (entries[slot].addr == look_addr_b) begin
          hit_b      = 1'b1;
          hit_data_b = entries[slot].data;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: queued write drain, one-hot read decode, bypass and registered read data.
// Optional build macro REGFILE_ZERO_REG_EN makes row 0 a hardwired zero register.
module regfile_access_ctrl
  import regfile_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int QDEPTH = QDEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_access_ctrl_if.slave wr,
  input  logic                 rd_en_a,
  input  logic [AW-1:0]        rd_addr_a,
  input  logic                 rd_en_b,
  input  logic [AW-1:0]        rd_addr_b,
  output logic [NREGS-1:0]     we_row,
  output logic [DW-1:0]        wdata,
  output logic [NREGS-1:0]     re_a_row,
  output logic [NREGS-1:0]     re_b_row,
  input  logic [DW-1:0]        bus_a,
  input  logic [DW-1:0]        bus_b,
  output logic [DW-1:0]        rd_data_a,
  output logic                 rd_valid_a,
  output logic [DW-1:0]        rd_data_b,
  output logic                 rd_valid_b
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  req_t          req_in;
  req_t          head_req;
  logic          push;
  logic          not_empty;
  logic          hit_a;
  logic          hit_b;
  logic [DW-1:0] hit_data_a;
  logic [DW-1:0] hit_data_b;
  logic [DW-1:0] wdata_last;

  // True when the address names a real, writable/readable row in the array.
  function automatic logic row_ok(input logic [AW-1:0] a);
`ifdef REGFILE_ZERO_REG_EN
    return (32'(a) < 32'(NREGS)) && (a != '0);
`else
    return (32'(a) < 32'(NREGS));
`endif
  endfunction

  function automatic logic [NREGS-1:0] row_dec(input logic [AW-1:0] a);
    return (NREGS)'(onehot(32'(a)));
  endfunction

  function automatic logic [DW-1:0] read_pick(input logic [AW-1:0] a, input logic hit,
                                              input logic [DW-1:0] fwd, input logic [DW-1:0] bus);
    if (!row_ok(a)) return '0;
    return hit ? fwd : bus;
  endfunction

  // Unmapped (or hardwired-zero) addresses still complete the handshake but are dropped here.
  assign push   = wr.wr_valid && row_ok(wr.wr_addr);
  assign req_in = '{addr: wr.wr_addr, data: wr.wr_data};

  regfile_wr_queue #(
    .AW    (AW),
    .DW    (DW),
    .QDEPTH(QDEPTH),
    .req_t (req_t)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_req   (req_in),
    .ready      (wr.wr_ready),
    .not_empty  (not_empty),
    .head_req   (head_req),
    .look_addr_a(rd_addr_a),
    .look_addr_b(rd_addr_b),
    .hit_a      (hit_a),
    .hit_b      (hit_b),
    .hit_data_a (hit_data_a),
    .hit_data_b (hit_data_b)
  );

  assign we_row   = not_empty ? row_dec(head_req.addr) : '0;
  assign wdata    = not_empty ? head_req.data : wdata_last;
  assign re_a_row = (rd_en_a && row_ok(rd_addr_a) && !hit_a) ? row_dec(rd_addr_a) : '0;
  assign re_b_row = (rd_en_b && row_ok(rd_addr_b) && !hit_b) ? row_dec(rd_addr_b) : '0;

  // Write-data bus keeps the last drained value while the queue is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata_last <= '0;
    end else if (not_empty) begin
      wdata_last <= head_req.data;
    end
  end

  // Read capture stage: data reflects cycle N, valid for cycle N+1 only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_a <= 1'b0;
      rd_valid_b <= 1'b0;
      rd_data_a  <= '0;
      rd_data_b  <= '0;
    end else begin
      rd_valid_a <= rd_en_a;
      rd_valid_b <= rd_en_b;
      if (rd_en_a) rd_data_a <= read_pick(rd_addr_a, hit_a, hit_data_a, bus_a);
      if (rd_en_b) rd_data_b <= read_pick(rd_addr_b, hit_b, hit_data_b, bus_b);
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl: a behavioural cell array plus a register-level reference model.
module tb_regfile_access_ctrl;

  localparam int NREGS  = 8;
  localparam int AW     = 4;
  localparam int DW     = 8;
  localparam int QDEPTH = 2;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             rd_en_a, rd_en_b;
  logic [AW-1:0]    rd_addr_a, rd_addr_b;
  logic [NREGS-1:0] we_row, re_a_row, re_b_row;
  logic [DW-1:0]    wdata, bus_a, bus_b, rd_data_a, rd_data_b;
  logic             rd_valid_a, rd_valid_b;

  regfile_access_ctrl_if #(.AW(AW), .DW(DW)) wif ();

  regfile_access_ctrl #(.NREGS(NREGS), .AW(AW), .DW(DW), .QDEPTH(QDEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr        (wif),
    .rd_en_a   (rd_en_a),
    .rd_addr_a (rd_addr_a),
    .rd_en_b   (rd_en_b),
    .rd_addr_b (rd_addr_b),
    .we_row    (we_row),
    .wdata     (wdata),
    .re_a_row  (re_a_row),
    .re_b_row  (re_b_row),
    .bus_a     (bus_a),
    .bus_b     (bus_b),
    .rd_data_a (rd_data_a),
    .rd_valid_a(rd_valid_a),
    .rd_data_b (rd_data_b),
    .rd_valid_b(rd_valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Behavioural cell array: one-hot enables, reads return pre-edge contents, undriven bus reads as 0xEE.
  logic [DW-1:0] mem [NREGS] = '{default: '0};
  int ia, ib, iw;

  function automatic int row_of(input logic [NREGS-1:0] r);
    int idx = -1;
    for (int i = 0; i < NREGS; i++)
      if (r[i]) begin
        if (idx >= 0) return -2;
        idx = i;
      end
    return idx;
  endfunction

  always_comb begin
    bus_a = 8'hEE;
    bus_b = 8'hEE;
    ia = row_of(re_a_row);
    ib = row_of(re_b_row);
    if (ia >= 0) bus_a = mem[ia[2:0]];
    if (ib >= 0) bus_b = mem[ib[2:0]];
  end

  always @(posedge clk) begin
    iw = row_of(we_row);
    if (iw >= 0) mem[iw[2:0]] <= wdata;
  end

  // Reference model: architectural register contents plus the list of accepted, not-yet-written requests.
  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct packed { int unsigned cyc; logic [DW-1:0] data; } rd_exp_t;

  wr_t           pend [$];
  rd_exp_t       sb_a [$];
  rd_exp_t       sb_b [$];
  logic [DW-1:0] shadow [NREGS] = '{default: '0};
  logic [DW-1:0] last_w = '0;
  logic [DW-1:0] hold_a = '0;
  logic [DW-1:0] hold_b = '0;
  int unsigned   cyc = 0;
  bit            acc;

  function automatic bit addr_ok(input logic [AW-1:0] a);
    return (int'(a) < NREGS) && !(ZR && a == '0);
  endfunction

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    return addr_ok(a) ? shadow[a[2:0]] : '0;
  endfunction

  function automatic logic [NREGS-1:0] oh(input logic [AW-1:0] a);
    logic [NREGS-1:0] one;
    one = 1;
    return (int'(a) < NREGS) ? (one << a) : '0;
  endfunction

  function automatic bit pend_has(input logic [AW-1:0] a);
    foreach (pend[i]) if (pend[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NREGS-1:0] exp_re(input logic en, input logic [AW-1:0] a);
    return (en && addr_ok(a) && !pend_has(a)) ? oh(a) : '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      sb_a.delete();
      sb_b.delete();
      last_w = '0;
      hold_a = '0;
      hold_b = '0;
    end else begin
      cyc++;
      if (rd_en_a) sb_a.push_back('{cyc, exp_read(rd_addr_a)});
      if (rd_en_b) sb_b.push_back('{cyc, exp_read(rd_addr_b)});
      acc = wif.wr_valid && (pend.size() < QDEPTH);
      if (pend.size() > 0) begin
        last_w = pend[0].data;
        void'(pend.pop_front());
      end
      if (acc && addr_ok(wif.wr_addr)) begin
        shadow[wif.wr_addr[2:0]] = wif.wr_data;
        pend.push_back('{wif.wr_addr, wif.wr_data});
      end
    end
  end

  // Monitor: compares combinational outputs and pops the read scoreboards when data is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("wr_ready", 32'(wif.wr_ready), 32'(pend.size() < QDEPTH));
      chk("we_row", 32'(we_row), 32'((pend.size() > 0) ? oh(pend[0].addr) : '0));
      chk("wdata", 32'(wdata), 32'((pend.size() > 0) ? pend[0].data : last_w));
      chk("re_a_row", 32'(re_a_row), 32'(exp_re(rd_en_a, rd_addr_a)));
      chk("re_b_row", 32'(re_b_row), 32'(exp_re(rd_en_b, rd_addr_b)));
      if (sb_a.size() > 0 && sb_a[0].cyc == cyc) begin
        chk("rd_valid_a", 32'(rd_valid_a), 32'(1));
        chk("rd_data_a", 32'(rd_data_a), 32'(sb_a[0].data));
        hold_a = sb_a[0].data;
        void'(sb_a.pop_front());
      end else begin
        chk("rd_valid_a_idle", 32'(rd_valid_a), 32'(0));
        chk("rd_data_a_hold", 32'(rd_data_a), 32'(hold_a));
      end
      if (sb_b.size() > 0 && sb_b[0].cyc == cyc) begin
        chk("rd_valid_b", 32'(rd_valid_b), 32'(1));
        chk("rd_data_b", 32'(rd_data_b), 32'(sb_b[0].data));
        hold_b = sb_b[0].data;
        void'(sb_b.pop_front());
      end else begin
        chk("rd_valid_b_idle", 32'(rd_valid_b), 32'(0));
        chk("rd_data_b_hold", 32'(rd_data_b), 32'(hold_b));
      end
    end
  end

  // Stimulus driver.
  logic rdy_s;

  task automatic step();
    @(negedge clk) rdy_s = wif.wr_ready;
    @(posedge clk);
    #1;
    if (wif.wr_valid && rdy_s) wif.wr_valid = 1'b0;
    rd_en_a = 1'b0;
    rd_en_b = 1'b0;
  endtask

  task automatic set_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wif.wr_valid = 1'b1;
    wif.wr_addr  = a;
    wif.wr_data  = d;
  endtask

  task automatic rd_a(input logic [AW-1:0] a);
    rd_en_a = 1'b1;
    rd_addr_a = a;
  endtask

  task automatic rd_b(input logic [AW-1:0] a);
    rd_en_b = 1'b1;
    rd_addr_b = a;
  endtask

  initial begin
    rst_n = 1'b0;
    wif.wr_valid = 1'b0;
    wif.wr_addr = '0;
    wif.wr_data = '0;
    rd_en_a = 1'b0;
    rd_en_b = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_ready", 32'(wif.wr_ready), 32'(1));
    chk("rst_we_row", 32'(we_row), 32'(0));
    chk("rst_wdata", 32'(wdata), 32'(0));
    chk("rst_re_rows", 32'({re_a_row, re_b_row}), 32'(0));
    chk("rst_rd_data", 32'({rd_data_a, rd_data_b}), 32'(0));
    chk("rst_rd_valid", 32'({rd_valid_a, rd_valid_b}), 32'(0));
    rst_n = 1'b1;
    step();

    // Write then read back through the array.
    set_wr(4'd3, 8'hA5); step();
    step(); step();
    rd_a(4'd3); step();
    step();

    // Back-to-back writes to one row, then an immediate read that must forward the younger data.
    set_wr(4'd5, 8'h11); step();
    set_wr(4'd5, 8'h22); step();
    rd_b(4'd5); step();
    step();

    // Unmapped addresses, a shared-address dual read, and address 0.
    rd_a(4'd9); rd_b(4'd3); step();
    set_wr(4'd9, 8'h77); step();
    step();
    rd_a(4'd3); rd_b(4'd3); step();
    set_wr(4'd0, 8'hFF); step();
    rd_a(4'd0); step();
    step();

    for (int n = 0; n < 600; n++) begin
      if (!wif.wr_valid && $urandom_range(0, 99) < 60)
        set_wr(AW'($urandom_range(0, 9)), DW'($urandom));
      rd_en_a = 1'($urandom);
      rd_addr_a = AW'($urandom_range(0, 9));
      rd_en_b = 1'($urandom);
      rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : AW'($urandom_range(0, 9));
      step();
    end
    wif.wr_valid = 1'b0;
    repeat (3) step();

    // Asynchronous reset while a write is still queued.
    set_wr(4'd2, 8'h5A); step();
    chk("pre_rst_we_row", 32'(we_row), 32'(8'h04));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we_row", 32'(we_row), 32'(0));
    chk("mid_rst_wr_ready", 32'(wif.wr_ready), 32'(1));
    chk("mid_rst_rd_valid", 32'({rd_valid_a, rd_valid_b}), 32'(0));
    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
